// File: rtl/t07_lcd_pkg.sv
// Shared timing defaults, FSM state encoding and a sync-level helper for the
// team_07 LCD raster generator.
package t07_lcd_pkg;

    localparam int   LCD_H_ACTIVE = 480;
    localparam int   LCD_H_FP     = 8;
    localparam int   LCD_H_SYNC   = 4;
    localparam int   LCD_H_BP     = 43;
    localparam int   LCD_V_ACTIVE = 272;
    localparam int   LCD_V_FP     = 4;
    localparam int   LCD_V_SYNC   = 4;
    localparam int   LCD_V_BP     = 12;
    localparam int   LCD_SETTLE   = 1024;
    localparam logic LCD_HS_POL   = 1'b0;
    localparam logic LCD_VS_POL   = 1'b0;

    typedef enum logic [1:0] {
        S_WAIT   = 2'd0,
        S_SETTLE = 2'd1,
        S_RUN    = 2'd2
    } lcd_state_e;

    // Drives the pin to the polarity level while asserted, to its complement otherwise.
    function automatic logic sync_level(input logic active, input logic pol);
        return active ? pol : ~pol;
    endfunction

endpackage

// File: rtl/t07_sync2.sv
// Two-flop synchronizer that brings the asynchronous PLL lock flag into the LCD clock domain.
module t07_sync2 (
    input  logic clk,
    input  logic rst,
    input  logic async_i,
    output logic sync_o
);

    logic [1:0] sync_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q <= 2'b00;
        end else begin
            sync_q <= {sync_q[0], async_i};
        end
    end

    assign sync_o = sync_q[1];

endmodule

// File: rtl/t07_lcd_timing_gen.sv
// LCD raster timing generator: waits for a settled PLL lock, then sweeps h/v counters
// and emits registered hsync/vsync/de, pixel coordinates and line/frame pulses.
module t07_lcd_timing_gen
    import t07_lcd_pkg::*;
#(
    parameter int   H_ACTIVE = LCD_H_ACTIVE,
    parameter int   H_FP     = LCD_H_FP,
    parameter int   H_SYNC   = LCD_H_SYNC,
    parameter int   H_BP     = LCD_H_BP,
    parameter int   V_ACTIVE = LCD_V_ACTIVE,
    parameter int   V_FP     = LCD_V_FP,
    parameter int   V_SYNC   = LCD_V_SYNC,
    parameter int   V_BP     = LCD_V_BP,
    parameter int   SETTLE   = LCD_SETTLE,
    parameter logic HS_POL   = LCD_HS_POL,
    parameter logic VS_POL   = LCD_VS_POL
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       pll_locked,
    input  logic       enable,
    output logic       hsync,
    output logic       vsync,
    output logic       de,
    output logic [9:0] px_x,
    output logic [8:0] px_y,
    output logic       line_start,
    output logic       frame_start,
    output logic       running,
    output logic [7:0] lock_loss_cnt
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int HW      = (H_TOTAL > 1) ? $clog2(H_TOTAL) : 1;
    localparam int VW      = (V_TOTAL > 1) ? $clog2(V_TOTAL) : 1;
    localparam int SW      = (SETTLE > 1) ? $clog2(SETTLE) : 1;

    localparam logic [HW-1:0] H_LAST     = HW'(H_TOTAL - 1);
    localparam logic [HW-1:0] H_ACT_END  = HW'(H_ACTIVE);
    localparam logic [HW-1:0] H_SYNC_BEG = HW'(H_ACTIVE + H_FP);
    localparam logic [HW-1:0] H_SYNC_END = HW'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [VW-1:0] V_LAST     = VW'(V_TOTAL - 1);
    localparam logic [VW-1:0] V_ACT_END  = VW'(V_ACTIVE);
    localparam logic [VW-1:0] V_SYNC_BEG = VW'(V_ACTIVE + V_FP);
    localparam logic [VW-1:0] V_SYNC_END = VW'(V_ACTIVE + V_FP + V_SYNC);
    localparam logic [SW-1:0] SETTLE_LAST = SW'(SETTLE - 1);

    logic          lk;
    lcd_state_e    state_q, state_d;
    logic [SW-1:0] settle_q, settle_d;
    logic [HW-1:0] h_q, h_d;
    logic [VW-1:0] v_q, v_d;
    logic [7:0]    loss_q, loss_d;
    logic [7:0]    loss_inc;
    logic          h_wrap, frame_end;

    logic       hs_q, vs_q, de_q, ls_q, fs_q;
    logic       hs_d, vs_d, de_d, ls_d, fs_d;
    logic [9:0] px_x_q, px_x_d;
    logic [8:0] px_y_q, px_y_d;
    logic       run_now;

    t07_sync2 u_lock_sync (
        .clk     (clk),
        .rst     (rst),
        .async_i (pll_locked),
        .sync_o  (lk)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= S_WAIT;
            settle_q <= '0;
            h_q      <= '0;
            v_q      <= '0;
            loss_q   <= 8'd0;
        end else begin
            state_q  <= state_d;
            settle_q <= settle_d;
            h_q      <= h_d;
            v_q      <= v_d;
            loss_q   <= loss_d;
        end
    end

    assign loss_inc  = (loss_q == 8'hFF) ? loss_q : loss_q + 8'd1;
    assign h_wrap    = (h_q == H_LAST);
    assign frame_end = h_wrap && (v_q == V_LAST);

    // Lock loss is tested before the frame-end stop so a coincident drop counts exactly once.
    always_comb begin
        state_d  = state_q;
        settle_d = settle_q;
        h_d      = h_q;
        v_d      = v_q;
        loss_d   = loss_q;
        unique case (state_q)
            S_WAIT: begin
                h_d = '0;
                v_d = '0;
                if (lk && enable) begin
                    state_d  = S_SETTLE;
                    settle_d = '0;
                end
            end
            S_SETTLE: begin
                if (!lk) begin
                    state_d = S_WAIT;
                    loss_d  = loss_inc;
                end else if (!enable) begin
                    state_d = S_WAIT;
                end else if (settle_q == SETTLE_LAST) begin
                    state_d = S_RUN;
                    h_d     = '0;
                    v_d     = '0;
                end else begin
                    settle_d = settle_q + 1'b1;
                end
            end
            S_RUN: begin
                if (!lk) begin
                    state_d = S_WAIT;
                    loss_d  = loss_inc;
                end else if (!enable && frame_end) begin
                    state_d = S_WAIT;
                end else begin
                    h_d = h_wrap ? '0 : h_q + 1'b1;
                    if (h_wrap) begin
                        v_d = (v_q == V_LAST) ? '0 : v_q + 1'b1;
                    end
                end
            end
            default: begin
                state_d = S_WAIT;
            end
        endcase
    end

    // Decode is gated by the current state, so outputs go idle one cycle after RUN is left.
    always_comb begin
        run_now = (state_q == S_RUN);
        de_d    = run_now && (h_q < H_ACT_END) && (v_q < V_ACT_END);
        hs_d    = sync_level(run_now && (h_q >= H_SYNC_BEG) && (h_q < H_SYNC_END), HS_POL);
        vs_d    = sync_level(run_now && (v_q >= V_SYNC_BEG) && (v_q < V_SYNC_END), VS_POL);
        ls_d    = run_now && (h_q == '0);
        fs_d    = run_now && (h_q == '0) && (v_q == '0);
        px_x_d  = de_d ? 10'(h_q) : 10'd0;
        px_y_d  = de_d ? 9'(v_q) : 9'd0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hs_q   <= ~HS_POL;
            vs_q   <= ~VS_POL;
            de_q   <= 1'b0;
            ls_q   <= 1'b0;
            fs_q   <= 1'b0;
            px_x_q <= 10'd0;
            px_y_q <= 9'd0;
        end else begin
            hs_q   <= hs_d;
            vs_q   <= vs_d;
            de_q   <= de_d;
            ls_q   <= ls_d;
            fs_q   <= fs_d;
            px_x_q <= px_x_d;
            px_y_q <= px_y_d;
        end
    end

    assign hsync         = hs_q;
    assign vsync         = vs_q;
    assign de            = de_q;
    assign px_x          = px_x_q;
    assign px_y          = px_y_q;
    assign line_start    = ls_q;
    assign frame_start   = fs_q;
    assign running       = (state_q == S_RUN);
    assign lock_loss_cnt = loss_q;

endmodule

// File: tb/tb_t07_lcd_timing_gen.sv
// Scoreboard bench for t07_lcd_timing_gen on a small 8x6 raster: a cycle model based on
// elapsed RUN time predicts every output, and a monitor compares them each cycle.
`timescale 1ns/1ps
module tb_t07_lcd_timing_gen;

    localparam int HA = 4, HF = 1, HS = 1, HB = 2;
    localparam int VA = 3, VF = 1, VS = 1, VB = 1;
    localparam int ST = 4;
    localparam int HT = HA + HF + HS + HB;
    localparam int VT = VA + VF + VS + VB;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       pll_locked = 1'b0;
    logic       enable = 1'b0;
    logic       hsync, vsync, de, line_start, frame_start, running;
    logic [9:0] px_x;
    logic [8:0] px_y;
    logic [7:0] lock_loss_cnt;

    always #5 clk = ~clk;

    t07_lcd_timing_gen #(
        .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
        .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
        .SETTLE(ST), .HS_POL(1'b0), .VS_POL(1'b0)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .pll_locked    (pll_locked),
        .enable        (enable),
        .hsync         (hsync),
        .vsync         (vsync),
        .de            (de),
        .px_x          (px_x),
        .px_y          (px_y),
        .line_start    (line_start),
        .frame_start   (frame_start),
        .running       (running),
        .lock_loss_cnt (lock_loss_cnt)
    );

    typedef struct packed {
        logic       hs;
        logic       vs;
        logic       de;
        logic [9:0] x;
        logic [8:0] y;
        logic       ls;
        logic       fs;
        logic       run;
        logic [7:0] cnt;
    } obs_t;

    obs_t expQ[$];
    int   checks = 0;
    int   failures = 0;

    int   mMode;
    int   mSettled;
    int   mRunT;
    int   mLoss;
    bit   mPipe0, mPipe1;

    function automatic obs_t idleObs();
        obs_t o;
        o = '0;
        o.hs = 1'b1;
        o.vs = 1'b1;
        return o;
    endfunction

    function automatic obs_t decodeAt(input int t, input bit active);
        obs_t o;
        int   h, v;
        o = idleObs();
        if (active) begin
            h    = t % HT;
            v    = (t / HT) % VT;
            o.de = (h < HA) && (v < VA);
            o.hs = !((h >= HA + HF) && (h < HA + HF + HS));
            o.vs = !((v >= VA + VF) && (v < VA + VF + VS));
            o.ls = (h == 0);
            o.fs = (h == 0) && (v == 0);
            o.x  = o.de ? 10'(h) : 10'd0;
            o.y  = o.de ? 9'(v) : 9'd0;
        end
        return o;
    endfunction

    function automatic obs_t sampleDut();
        obs_t a;
        a.hs  = hsync;
        a.vs  = vsync;
        a.de  = de;
        a.x   = px_x;
        a.y   = px_y;
        a.ls  = line_start;
        a.fs  = frame_start;
        a.run = running;
        a.cnt = lock_loss_cnt;
        return a;
    endfunction

    task automatic modelReset();
        mMode    = 0;
        mSettled = 0;
        mRunT    = 0;
        mLoss    = 0;
        mPipe0   = 1'b0;
        mPipe1   = 1'b0;
    endtask

    // One clock edge of the reference: RUN position is elapsed RUN cycles modulo the frame.
    task automatic modelStep(input bit pll, input bit en, input bit rstv);
        obs_t e;
        bit   lkNow;
        int   h, v;
        if (rstv) begin
            modelReset();
            expQ.push_back(idleObs());
            return;
        end
        lkNow = mPipe1;
        e     = decodeAt(mRunT, mMode == 2);
        h     = mRunT % HT;
        v     = (mRunT / HT) % VT;
        case (mMode)
            0: if (lkNow && en) begin mMode = 1; mSettled = 0; end
            1: begin
                if (!lkNow) begin mMode = 0; if (mLoss < 255) mLoss++; end
                else if (!en) mMode = 0;
                else if (mSettled == ST - 1) begin mMode = 2; mRunT = 0; end
                else mSettled++;
            end
            default: begin
                if (!lkNow) begin mMode = 0; if (mLoss < 255) mLoss++; end
                else if (!en && h == HT - 1 && v == VT - 1) mMode = 0;
                else mRunT = (mRunT + 1) % (HT * VT);
            end
        endcase
        mPipe1 = mPipe0;
        mPipe0 = pll;
        e.run  = (mMode == 2);
        e.cnt  = 8'(mLoss);
        expQ.push_back(e);
    endtask

    task automatic checkOutput(input string name, input obs_t a, input obs_t e);
        checks++;
        if (a !== e) begin
            failures++;
            $display("[TB] FAIL %s t=%0t got hs=%b vs=%b de=%b x=%0d y=%0d ls=%b fs=%b run=%b cnt=%0d want hs=%b vs=%b de=%b x=%0d y=%0d ls=%b fs=%b run=%b cnt=%0d",
                     name, $time, a.hs, a.vs, a.de, a.x, a.y, a.ls, a.fs, a.run, a.cnt,
                     e.hs, e.vs, e.de, e.x, e.y, e.ls, e.fs, e.run, e.cnt);
        end
    endtask

    task automatic applyStimulus(input bit pll, input bit en, input bit rstv = 1'b0);
        @(negedge clk);
        rst        = rstv;
        pll_locked = pll;
        enable     = en;
        @(posedge clk);
        modelStep(pll, en, rstv);
    endtask

    // Asserts reset between edges and expects idle outputs immediately, not at the next edge.
    task automatic midCycleReset();
        @(negedge clk);
        #1 rst = 1'b1;
        #1;
        modelReset();
        checkOutput("async_reset", sampleDut(), idleObs());
        repeat (2) applyStimulus(1'b1, 1'b1, 1'b1);
    endtask

    initial begin
        obs_t e;
        forever begin
            @(negedge clk);
            if (expQ.size() > 0) begin
                e = expQ.pop_front();
                checkOutput("scoreboard", sampleDut(), e);
            end
        end
    end

    initial begin
        obs_t want;
        modelReset();
        repeat (3) applyStimulus(1'b0, 1'b0, 1'b1);
        #1;
        checkOutput("reset_state", sampleDut(), idleObs());

        repeat (200) applyStimulus(1'b1, 1'b1);

        repeat (6) begin
            repeat ($urandom_range(0, 47)) applyStimulus(1'b1, 1'b1);
            repeat ($urandom_range(1, 3)) applyStimulus(1'b0, 1'b1);
            repeat (60) applyStimulus(1'b1, 1'b1);
        end

        repeat (8) begin
            repeat (3) applyStimulus(1'b0, 1'b1);
            repeat (2 + $urandom_range(0, 5)) applyStimulus(1'b1, 1'b1);
            applyStimulus(1'b0, 1'b1);
            repeat (14) applyStimulus(1'b1, 1'b1);
        end

        repeat (8) begin
            repeat ($urandom_range(0, 60)) applyStimulus(1'b1, 1'b1);
            repeat ($urandom_range(1, 60)) applyStimulus(1'b1, 1'b0);
            repeat (70) applyStimulus(1'b1, 1'b1);
        end

        repeat (1500) begin
            applyStimulus($urandom_range(0, 99) < 97, $urandom_range(0, 99) < 95);
        end

        repeat (300) begin
            repeat (3) applyStimulus(1'b1, 1'b1);
            repeat (2) applyStimulus(1'b0, 1'b1);
        end
        #1;
        checks++;
        if (lock_loss_cnt !== 8'd255) begin
            failures++;
            $display("[TB] FAIL cnt_saturate got %0d want 255", lock_loss_cnt);
        end

        repeat (30) applyStimulus(1'b1, 1'b1);
        midCycleReset();
        repeat (120) applyStimulus(1'b1, 1'b1);
        midCycleReset();
        repeat (60) applyStimulus(1'b1, 1'b1);

        repeat (2) @(negedge clk);
        #1;
        want = '0;
        checks++;
        if (expQ.size() != 0) begin
            failures++;
            $display("[TB] FAIL queue_drain got %0d want %0d", expQ.size(), want.cnt);
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
